// File: rtl/fir16_pkg.sv
// Shared constants and types for the serial 16-tap FIR multiply-accumulate stage.
package fir16_pkg;

    localparam int TAPS   = 16;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 36;   // 2*DATA_W + log2(TAPS): 16 full-scale products cannot overflow
    localparam int FRAC   = 15;
    localparam int IDX_W  = 4;

    // Controller states, kept as plain constants so the encoding stays fixed and visible.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t ROUND = 2'd2;

    typedef logic signed [DATA_W-1:0]   sample_t;
    typedef logic signed [DATA_W-1:0]   coeff_t;
    typedef logic signed [2*DATA_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

endpackage

// File: rtl/fir16_mac_serial_if.sv
// Window/result bus between the FIR tap register, the MAC stage and its consumer.
interface fir16_mac_serial_if;
    import fir16_pkg::*;

    logic                    sample_valid;
    logic [TAPS*DATA_W-1:0]  samples_flat;
    logic [TAPS*DATA_W-1:0]  coeffs_flat;
    sample_t                 y_out;
    logic                    y_valid;
    logic                    busy;
    logic                    overrun;

    // Upstream side: presents windows, observes results and status.
    modport master (
        output sample_valid, samples_flat, coeffs_flat,
        input  y_out, y_valid, busy, overrun
    );

    // MAC side.
    modport slave (
        input  sample_valid, samples_flat, coeffs_flat,
        output y_out, y_valid, busy, overrun
    );

endinterface

// File: rtl/fir16_round_sat.sv
// Combinational round-half-up and saturation of a Q.30 accumulator to Q1.15.
module fir16_round_sat
    import fir16_pkg::*;
(
    input  acc_t    i_acc,
    output sample_t o_y
);

    localparam acc_t SAT_MAX = acc_t'(32767);
    localparam acc_t SAT_MIN = acc_t'(-32768);

    acc_t w_biased;
    acc_t w_shifted;

    // Adding half an output LSB before the arithmetic shift rounds ties upward.
    assign w_biased  = i_acc + acc_t'(1 <<< (FRAC - 1));
    assign w_shifted = w_biased >>> FRAC;

    // Clamp the rounded value into the 16-bit signed output range.
    always_comb begin
        // NOTE: o_y gets a value on every path through this block, so no latch is inferred.
        o_y = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            o_y = sample_t'(SAT_MAX);
        end else if (w_shifted < SAT_MIN) begin
            o_y = sample_t'(SAT_MIN);
        end
    end

endmodule

// File: rtl/fir16_mac_serial.sv
// Serial MAC: one 16x16 multiplier walks the captured 16-tap window over 16 cycles,
// then rounds/saturates the sum to Q1.15 and emits it with a one-cycle valid pulse.
module fir16_mac_serial
    import fir16_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    fir16_mac_serial_if.slave  bus
);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    acc_t                   r_acc;
    logic [TAPS*DATA_W-1:0] r_samples;
    logic [TAPS*DATA_W-1:0] r_coeffs;
    sample_t                r_y_out;
    logic                   r_y_valid;
    logic                   r_overrun;

    sample_t w_x;
    coeff_t  w_h;
    prod_t   w_prod;
    acc_t    w_prod_ext;
    sample_t w_rounded;

    // 16:1 tap/coefficient select from the captured window.
    assign w_x        = r_samples[r_idx*DATA_W +: DATA_W];
    assign w_h        = r_coeffs[r_idx*DATA_W +: DATA_W];
    assign w_prod     = w_x * w_h;
    assign w_prod_ext = acc_t'(w_prod);

    fir16_round_sat u_round_sat (
        .i_acc (r_acc),
        .o_y   (w_rounded)
    );

    // Controller and datapath: capture in IDLE, accumulate 16 products, round once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_acc     <= '0;
            // NOTE: the capture registers are cleared so no stale window survives a reset.
            r_samples <= '0;
            r_coeffs  <= '0;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_y_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        r_samples <= bus.samples_flat;
                        r_coeffs  <= bus.coeffs_flat;
                        r_acc     <= '0;
                        r_idx     <= '0;
                        r_state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'(TAPS - 1)) begin
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    r_y_out   <= w_rounded;
                    r_y_valid <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky flag: a strobe arriving mid-computation is dropped and remembered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (bus.sample_valid && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign bus.y_out   = r_y_out;
    assign bus.y_valid = r_y_valid;
    assign bus.busy    = (r_state != IDLE);
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_fir16_mac_serial.sv
// Directed and randomized checks of fir16_mac_serial against an arithmetic reference.
module tb_fir16_mac_serial;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    fir16_mac_serial_if bus ();

    fir16_mac_serial dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something escapes the per-wait cycle budgets.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: y = sat16(round((sum of h[k]*x[k]) / 2^15)), plain integer arithmetic.
    function automatic logic [15:0] ref_y(input logic [255:0] s, input logic [255:0] c);
        longint sum;
        longint r;
        sum = 0;
        for (int k = 0; k < 16; k++) begin
            sum += longint'($signed(s[k*16 +: 16])) * longint'($signed(c[k*16 +: 16]));
        end
        r = (sum + 64'sd16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    function automatic logic [255:0] rand_window(input int shr);
        logic [255:0]       w;
        logic signed [15:0] v;
        for (int k = 0; k < 16; k++) begin
            v = 16'($urandom());
            v = v >>> shr;
            w[k*16 +: 16] = v;
        end
        return w;
    endfunction

    // Present one window, then wait (bounded) for its result.
    // lat counts rising edges after the acceptance edge until y_valid is seen.
    task automatic run_window(input string tag, input logic [255:0] s, input logic [255:0] c,
                              output int lat, output logic [15:0] y);
        @(negedge clk);
        bus.samples_flat = s;
        bus.coeffs_flat  = c;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        // Scramble the inputs: the in-flight result must depend only on the capture.
        bus.samples_flat = rand_window(0);
        bus.coeffs_flat  = rand_window(0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        lat = 0;
        y   = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.y_valid) begin
                lat = i;
                y   = bus.y_out;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd17);
        check({tag, "_y"}, 64'(y), 64'(ref_y(s, c)));
    endtask

    initial begin
        logic [255:0] s, c, s2, c2;
        logic [15:0]  y;
        int           lat;
        int           pulses;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.sample_valid = 1'b0;
        bus.samples_flat = '0;
        bus.coeffs_flat  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_y_out",   64'(bus.y_out),   64'd0);
        check("rst_y_valid", 64'(bus.y_valid), 64'd0);
        check("rst_busy",    64'(bus.busy),    64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Impulse: only x[0]*h[0] = 0x4000*0x0100 contributes
        s = '0;
        s[15:0] = 16'h4000;
        for (int k = 0; k < 16; k++) c[k*16 +: 16] = 16'h0100;
        c[3*16 +: 16] = 16'h4000;
        run_window("impulse", s, c, lat, y);
        check("impulse_const", 64'(y), 64'h0080);
        @(posedge clk);
        #1;
        check("impulse_pulse_end", 64'(bus.y_valid), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Full-scale saturation, both signs
        for (int k = 0; k < 16; k++) begin
            s[k*16 +: 16] = 16'h7FFF;
            c[k*16 +: 16] = 16'h7FFF;
        end
        run_window("sat_pos", s, c, lat, y);
        check("sat_pos_const", 64'(y), 64'h7FFF);
        for (int k = 0; k < 16; k++) s[k*16 +: 16] = 16'h8000;
        run_window("sat_neg", s, c, lat, y);
        check("sat_neg_const", 64'(y), 64'h8000);

        // Rounding of exactly half an LSB, positive and negative
        s = '0;
        c = '0;
        s[5*16 +: 16] = 16'h0001;
        c[5*16 +: 16] = 16'h4000;
        run_window("round_pos", s, c, lat, y);
        check("round_pos_const", 64'(y), 64'h0001);
        s[5*16 +: 16] = 16'hFFFF;
        run_window("round_neg", s, c, lat, y);
        check("round_neg_const", 64'(y), 64'h0000);

        // Randomized windows with a mix of coefficient magnitudes
        for (int t = 0; t < 8; t++) begin
            run_window("random", rand_window(0), rand_window(t % 4), lat, y);
        end

        // Back-to-back: strobe in the y_valid cycle is accepted
        s = rand_window(0);
        c = rand_window(2);
        run_window("b2b_first", s, c, lat, y);
        s2 = rand_window(1);
        c2 = rand_window(3);
        bus.samples_flat = s2;
        bus.coeffs_flat  = c2;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        check("b2b_accept_busy", 64'(bus.busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.y_valid) begin
                lat = i;
                y   = bus.y_out;
                break;
            end
        end
        check("b2b_second_latency", 64'(lat), 64'd17);
        check("b2b_second_y", 64'(y), 64'(ref_y(s2, c2)));
        check("b2b_no_overrun", 64'(bus.overrun), 64'd0);

        // Overrun: second strobe 5 cycles after acceptance is dropped
        s  = rand_window(0);
        c  = rand_window(2);
        s2 = rand_window(0);
        c2 = rand_window(1);
        @(negedge clk);
        bus.samples_flat = s;
        bus.coeffs_flat  = c;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.samples_flat = s2;
        bus.coeffs_flat  = c2;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        check("ovr_flag", 64'(bus.overrun), 64'd1);
        pulses = 0;
        lat    = 0;
        for (int i = 6; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (bus.y_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = i;
                    y   = bus.y_out;
                end
            end
        end
        check("ovr_pulses", 64'(pulses), 64'd1);
        check("ovr_latency", 64'(lat), 64'd17);
        check("ovr_y_first_window", 64'(y), 64'(ref_y(s, c)));
        check("ovr_sticky", 64'(bus.overrun), 64'd1);

        // Reset mid-ACCUM: nothing emitted, everything cleared
        s = rand_window(0);
        c = rand_window(1);
        @(negedge clk);
        bus.samples_flat = s;
        bus.coeffs_flat  = c;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_y_out",   64'(bus.y_out),   64'd0);
        check("mid_rst_y_valid", 64'(bus.y_valid), 64'd0);
        check("mid_rst_busy",    64'(bus.busy),    64'd0);
        check("mid_rst_overrun", 64'(bus.overrun), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (bus.y_valid) pulses++;
        end
        check("mid_rst_no_pulse", 64'(pulses), 64'd0);
        check("mid_rst_idle", 64'(bus.busy), 64'd0);
        run_window("post_rst", rand_window(0), rand_window(2), lat, y);
        check("post_rst_overrun", 64'(bus.overrun), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
